// File: rtl/hazard_fwd_ctrl.sv
// hazard_fwd_ctrl: EX-stage hazard controller.
// Chooses a forwarding source for each EX operand, sequences load-use and
// multi-cycle-op stalls, and keeps a saturating count of EX hold cycles.
module hazard_fwd_ctrl #(
    parameter int AW          = 4,
    parameter int NSRC        = 2,
    parameter int SPECIAL_REG = 0,
    parameter int MC_LAT      = 4,
    parameter int CNT_W       = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NSRC*AW-1:0]   ra_ex,
    input  logic [NSRC-1:0]      src_valid_ex,
    input  logic [AW-1:0]        wa_mem,
    input  logic                 regwrite_mem,
    input  logic                 memread_mem,
    input  logic [AW-1:0]        wa_wb,
    input  logic                 regwrite_wb,
    input  logic                 spw_wb,
    input  logic                 mc_start,
    output logic [2*NSRC-1:0]    fwd_sel,
    output logic                 hold_ex,
    output logic                 bubble_mem,
    output logic                 mc_busy,
    output logic [CNT_W-1:0]     stall_cnt
);

    // The accept cycle is itself the first held cycle, so the MC state only
    // has to cover the remaining MC_LAT-2 cycles (none when MC_LAT <= 2).
    localparam int MC_LOAD = (MC_LAT > 2) ? MC_LAT - 3 : 0;
    localparam int CW      = (MC_LAT > 3) ? $clog2(MC_LAT - 2) : 1;

    typedef enum logic [1:0] {
        RUN = 2'd0,
        LU  = 2'd1,
        MC  = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   mc_cnt;
    logic [CW-1:0]   mc_cnt_nxt;
    logic            lu_match;
    logic            lu_hit;

    // Per-source forwarding select and load-use address match.
    always_comb begin
        // NOTE: every signal driven here gets a default first so no path can leave it unassigned and infer a latch.
        fwd_sel  = '0;
        lu_match = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            if (src_valid_ex[i] && !rst) begin
                if (regwrite_mem && !memread_mem && (wa_mem == ra_ex[i*AW +: AW]))
                    fwd_sel[2*i +: 2] = 2'd1;
                else if (regwrite_wb && (wa_wb == ra_ex[i*AW +: AW]))
                    fwd_sel[2*i +: 2] = 2'd2;
                else if (spw_wb && (ra_ex[i*AW +: AW] == AW'(SPECIAL_REG)))
                    fwd_sel[2*i +: 2] = 2'd3;
                if (wa_mem == ra_ex[i*AW +: AW])
                    lu_match = 1'b1;
            end
        end
    end

    assign lu_hit = (state == RUN) && memread_mem && regwrite_mem && lu_match;

    // Stall decisions and next-state for the RUN/LU/MC sequencer.
    always_comb begin
        state_nxt  = state;
        mc_cnt_nxt = mc_cnt;
        hold_ex    = 1'b0;
        bubble_mem = 1'b0;
        mc_busy    = 1'b0;
        case (state)
            RUN, LU: begin
                if (lu_hit) begin
                    hold_ex    = 1'b1;
                    bubble_mem = 1'b1;
                    state_nxt  = LU;
                end else if (mc_start) begin
                    mc_busy = 1'b1;
                    if (MC_LAT > 1) begin
                        hold_ex    = 1'b1;
                        bubble_mem = 1'b1;
                    end
                    if (MC_LAT > 2) begin
                        state_nxt  = MC;
                        mc_cnt_nxt = CW'(MC_LOAD);
                    end else begin
                        state_nxt = RUN;
                    end
                end else begin
                    state_nxt = RUN;
                end
            end
            MC: begin
                hold_ex    = 1'b1;
                bubble_mem = 1'b1;
                mc_busy    = 1'b1;
                if (mc_cnt == '0)
                    state_nxt = RUN;
                else
                    mc_cnt_nxt = mc_cnt - CW'(1);
            end
            default: state_nxt = RUN;
        endcase
        if (rst) begin
            hold_ex    = 1'b0;
            bubble_mem = 1'b0;
            mc_busy    = 1'b0;
        end
    end

    // State, multi-cycle counter and saturating stall counter registers.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state     <= RUN;
            mc_cnt    <= '0;
            stall_cnt <= '0;
        end else begin
            state  <= state_nxt;
            mc_cnt <= mc_cnt_nxt;
            if (hold_ex && (stall_cnt != {CNT_W{1'b1}}))
                stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// tb_hazard_fwd_ctrl: directed vectors with a scoreboard queue.
// The driver pushes the hand-computed expectation for each cycle; a monitor
// samples the DUTs on the falling edge and compares against the queue head.
module tb_hazard_fwd_ctrl;

    typedef struct packed {
        logic       rst;
        logic [7:0] ra;
        logic [1:0] sv;
        logic [3:0] wm;
        logic       rwm;
        logic       mrd;
        logic [3:0] ww;
        logic       rww;
        logic       spw;
        logic       mcs;
    } stim_t;

    typedef struct {
        string       name;
        logic [3:0]  fwd;
        logic        hold;
        logic        bub;
        logic        busy;
        logic [15:0] cnt;
        logic [1:0]  cnt2;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  ra_ex = '0;
    logic [1:0]  src_valid_ex = '0;
    logic [3:0]  wa_mem = '0;
    logic        regwrite_mem = 1'b0;
    logic        memread_mem = 1'b0;
    logic [3:0]  wa_wb = '0;
    logic        regwrite_wb = 1'b0;
    logic        spw_wb = 1'b0;
    logic        mc_start = 1'b0;

    logic [3:0]  fwd_sel, fwd_sel2;
    logic        hold_ex, hold_ex2;
    logic        bubble_mem, bubble_mem2;
    logic        mc_busy, mc_busy2;
    logic [15:0] stall_cnt;
    logic [1:0]  stall_cnt2;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   run_cnt = 0;
    int   run_cnt2 = 0;

    always #5 clk = ~clk;

    hazard_fwd_ctrl #(.AW(4), .NSRC(2), .SPECIAL_REG(0), .MC_LAT(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .ra_ex(ra_ex), .src_valid_ex(src_valid_ex),
        .wa_mem(wa_mem), .regwrite_mem(regwrite_mem), .memread_mem(memread_mem),
        .wa_wb(wa_wb), .regwrite_wb(regwrite_wb), .spw_wb(spw_wb), .mc_start(mc_start),
        .fwd_sel(fwd_sel), .hold_ex(hold_ex), .bubble_mem(bubble_mem),
        .mc_busy(mc_busy), .stall_cnt(stall_cnt)
    );

    hazard_fwd_ctrl #(.AW(4), .NSRC(2), .SPECIAL_REG(0), .MC_LAT(4), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .ra_ex(ra_ex), .src_valid_ex(src_valid_ex),
        .wa_mem(wa_mem), .regwrite_mem(regwrite_mem), .memread_mem(memread_mem),
        .wa_wb(wa_wb), .regwrite_wb(regwrite_wb), .spw_wb(spw_wb), .mc_start(mc_start),
        .fwd_sel(fwd_sel2), .hold_ex(hold_ex2), .bubble_mem(bubble_mem2),
        .mc_busy(mc_busy2), .stall_cnt(stall_cnt2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic stim_t mk(input logic r, input logic [7:0] ra, input logic [1:0] sv,
                                 input logic [3:0] wm, input logic rwm, input logic mrd,
                                 input logic [3:0] ww, input logic rww, input logic spw,
                                 input logic mcs);
        stim_t s;
        s.rst = r; s.ra = ra; s.sv = sv; s.wm = wm; s.rwm = rwm; s.mrd = mrd;
        s.ww = ww; s.rww = rww; s.spw = spw; s.mcs = mcs;
        return s;
    endfunction

    // Drive one cycle of inputs and queue what the DUTs must show during it.
    task automatic apply(input string name, input stim_t s, input logic [3:0] e_fwd,
                         input logic e_hold, input logic e_bub, input logic e_busy);
        exp_t e;
        @(posedge clk);
        #1;
        rst = s.rst; ra_ex = s.ra; src_valid_ex = s.sv; wa_mem = s.wm;
        regwrite_mem = s.rwm; memread_mem = s.mrd; wa_wb = s.ww; regwrite_wb = s.rww;
        spw_wb = s.spw; mc_start = s.mcs;
        e.name = name; e.fwd = e_fwd; e.hold = e_hold; e.bub = e_bub; e.busy = e_busy;
        e.cnt = 16'(run_cnt); e.cnt2 = 2'(run_cnt2);
        q.push_back(e);
        if (s.rst) begin
            run_cnt  = 0;
            run_cnt2 = 0;
        end else if (e_hold) begin
            run_cnt++;
            if (run_cnt2 < 3) run_cnt2++;
        end
    endtask

    // Monitor: compare the queue head against both DUTs on every falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                check({e.name, ".fwd_sel"},    32'(fwd_sel),    32'(e.fwd));
                check({e.name, ".hold_ex"},    32'(hold_ex),    32'(e.hold));
                check({e.name, ".bubble_mem"}, 32'(bubble_mem), 32'(e.bub));
                check({e.name, ".mc_busy"},    32'(mc_busy),    32'(e.busy));
                check({e.name, ".stall_cnt"},  32'(stall_cnt),  32'(e.cnt));
                check({e.name, ".fwd_sel_w2"}, 32'(fwd_sel2),   32'(e.fwd));
                check({e.name, ".hold_ex_w2"}, 32'(hold_ex2),   32'(e.hold));
                check({e.name, ".stall_cnt_w2"}, 32'(stall_cnt2), 32'(e.cnt2));
            end
        end
    end

    initial begin
        stim_t nt;
        stim_t ld;
        stim_t mc;
        nt = mk(0, 8'h11, 2'b00, 4'hA, 0, 0, 4'hB, 0, 0, 0);
        mc = mk(0, 8'h11, 2'b00, 4'hA, 0, 0, 4'hB, 0, 0, 1);
        ld = mk(0, 8'h05, 2'b01, 4'h5, 1, 1, 4'h9, 0, 0, 0);
        repeat (2) @(posedge clk);

        apply("rst_outputs",   mk(1, 8'h33, 2'b11, 4'h3, 1, 0, 4'h3, 1, 0, 0), 4'b0000, 0, 0, 0);
        apply("fwd_mem_both",  mk(0, 8'h33, 2'b11, 4'h3, 1, 0, 4'h3, 1, 0, 0), 4'b0101, 0, 0, 0);
        apply("fwd_mem_wb",    mk(0, 8'h23, 2'b11, 4'h3, 1, 0, 4'h2, 1, 0, 0), 4'b1001, 0, 0, 0);
        apply("fwd_wb_only",   mk(0, 8'h33, 2'b11, 4'h3, 0, 0, 4'h3, 1, 0, 0), 4'b1010, 0, 0, 0);
        apply("fwd_special",   mk(0, 8'h00, 2'b11, 4'h4, 1, 0, 4'h6, 1, 1, 0), 4'b1111, 0, 0, 0);
        apply("fwd_prio_mem",  mk(0, 8'h00, 2'b11, 4'h0, 1, 0, 4'h0, 1, 1, 0), 4'b0101, 0, 0, 0);
        apply("fwd_prio_wb",   mk(0, 8'h00, 2'b10, 4'h4, 0, 0, 4'h0, 1, 1, 0), 4'b1000, 0, 0, 0);
        apply("lu_stall",      ld,                                             4'b0000, 1, 1, 0);
        apply("lu_release",    mk(0, 8'h05, 2'b01, 4'h5, 1, 1, 4'h5, 1, 0, 0), 4'b0010, 0, 0, 0);
        apply("lu_invalid_src", mk(0, 8'h51, 2'b01, 4'h5, 1, 1, 4'h0, 0, 0, 0), 4'b0000, 0, 0, 0);
        apply("idle",          nt,                                             4'b0000, 0, 0, 0);
        apply("mc_accept",     mc,                                             4'b0000, 1, 1, 1);
        apply("mc_hold1",      mc,                                             4'b0000, 1, 1, 1);
        apply("mc_hold2",      nt,                                             4'b0000, 1, 1, 1);
        apply("mc_done",       nt,                                             4'b0000, 0, 0, 0);
        apply("lu_over_mc",    mk(0, 8'h05, 2'b01, 4'h5, 1, 1, 4'h9, 0, 0, 1), 4'b0000, 1, 1, 0);
        apply("lu_to_mc",      mk(0, 8'h05, 2'b01, 4'h7, 0, 0, 4'h5, 1, 0, 1), 4'b0010, 1, 1, 1);
        apply("lu_mc_hold1",   nt,                                             4'b0000, 1, 1, 1);
        apply("lu_mc_hold2",   nt,                                             4'b0000, 1, 1, 1);
        apply("lu_mc_done",    nt,                                             4'b0000, 0, 0, 0);
        apply("mc2_accept",    mc,                                             4'b0000, 1, 1, 1);
        apply("rst_mid_mc",    mk(1, 8'h11, 2'b00, 4'hA, 0, 0, 4'hB, 0, 0, 0), 4'b0000, 0, 0, 0);
        apply("post_rst",      nt,                                             4'b0000, 0, 0, 0);
        apply("sat_mc_accept", mc,                                             4'b0000, 1, 1, 1);
        apply("sat_mc_hold1",  nt,                                             4'b0000, 1, 1, 1);
        apply("sat_mc_hold2",  nt,                                             4'b0000, 1, 1, 1);
        apply("sat_mc_done",   nt,                                             4'b0000, 0, 0, 0);
        apply("sat_lu1",       ld,                                             4'b0000, 1, 1, 0);
        apply("sat_lu1_rel",   nt,                                             4'b0000, 0, 0, 0);
        apply("sat_lu2",       ld,                                             4'b0000, 1, 1, 0);
        apply("sat_lu2_rel",   nt,                                             4'b0000, 0, 0, 0);
        apply("sat_final",     nt,                                             4'b0000, 0, 0, 0);

        for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
